// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the sequential multiplier: data width and the team ALU
// opcode values the multiplier drives onto the shared ALU.
package alu_mul_seq_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ALU_OP_W = 4;

  // Team ALU opcodes
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL = 4'b1101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 4'b1111;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Handshake and shared-ALU bundle between the multiplier and its parent.
//   start/op_a/op_b : request and operands (parent -> multiplier)
//   busy/done/result: status and held product (multiplier -> parent)
//   alu_a/alu_b/alu_op: shared ALU inputs while busy (multiplier -> ALU)
//   alu_out         : shared ALU result, same cycle (ALU -> multiplier)
interface alu_mul_seq_if;
  import alu_mul_seq_pkg::*;

  logic                start;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [DATA_W-1:0]   alu_out;

  // Parent / ALU side
  modport master (
    output start, op_a, op_b, alu_out,
    input  busy, done, result, alu_a, alu_b, alu_op
  );

  // Multiplier side
  modport slave (
    input  start, op_a, op_b, alu_out,
    output busy, done, result, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the shared 32-bit ALU.
// Produces the low 32 bits of op_a*op_b; result holds until the next product.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : alu_mul_seq_if.slave (start/op_a/op_b in, busy/done/result out,
//             alu_a/alu_b/alu_op out to the ALU, alu_out back from the ALU)
// Parameters:
//   N_BITS  : multiplier bits processed (1..32)
// Build option:
//   MUL_EARLY_EXIT_EN : finish as soon as the remaining multiplier bits are zero
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned N_BITS = 32
) (
  input logic          clk,
  input logic          rst,
  alu_mul_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SHL  = 3'd2,
    ST_SHR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_acc,    w_acc_nxt;
  logic [DATA_W-1:0]   r_mcand,  w_mcand_nxt;
  logic [DATA_W-1:0]   r_mplier, w_mplier_nxt;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
  logic [DATA_W-1:0]   r_result, w_result_nxt;
  logic [DATA_W-1:0]   w_alu_a;
  logic [DATA_W-1:0]   w_alu_b;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_last;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // ALU operand/opcode decode; kept apart from next-state logic because
  // alu_out depends combinationally on these through the external ALU.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = ALU_OP_NOP;
    case (r_state)
      ST_ADD: begin
        w_alu_a  = r_acc;
        w_alu_b  = r_mcand;
        w_alu_op = ALU_OP_ADD;
      end
      ST_SHL: begin
        w_alu_a  = r_mcand;
        w_alu_b  = DATA_W'(1);
        w_alu_op = ALU_OP_SLL;
      end
      ST_SHR: begin
        w_alu_a  = r_mplier;
        w_alu_b  = DATA_W'(1);
        w_alu_op = ALU_OP_SRL;
      end
      default: ;
    endcase
  end

  // Last iteration: all N_BITS multiplier bits consumed, or (optionally)
  // no set bits remain in the shifted multiplier.
`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == CNT_W'(N_BITS - 1)) || (bus.alu_out == '0);
`else
  assign w_last = (r_cnt == CNT_W'(N_BITS - 1));
`endif

  // Next-state and register updates; ALU results are captured on the same edge
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mcand_nxt  = bus.op_a;
          w_mplier_nxt = bus.op_b;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = bus.op_b[0] ? ST_ADD : ST_SHL;
        end
      end
      ST_ADD: begin
        w_acc_nxt   = bus.alu_out;
        w_state_nxt = ST_SHL;
      end
      ST_SHL: begin
        w_mcand_nxt = bus.alu_out;
        w_state_nxt = ST_SHR;
      end
      ST_SHR: begin
        w_mplier_nxt = bus.alu_out;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (w_last)
          w_state_nxt = ST_DONE;
        else
          w_state_nxt = bus.alu_out[0] ? ST_ADD : ST_SHL;
      end
      ST_DONE: begin
        w_result_nxt = r_acc;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.alu_a  = w_alu_a;
  assign bus.alu_b  = w_alu_b;
  assign bus.alu_op = w_alu_op;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;

endmodule
